// File: rtl/input_memory_read_arbiter_pkg.sv
// Shared types and defaults for the input-memory read arbiter.
package input_memory_read_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arbState_t;

  localparam int DEFAULT_NUM_REQ         = 4;
  localparam int DEFAULT_ADDR_W          = 17;
  localparam int DEFAULT_DATA_W          = 32;
  localparam int DEFAULT_MAX_OUTSTANDING = 4;

  // Bits needed to name one lane; never less than one bit.
  function automatic int laneIdWidth(input int numReq);
    return (numReq <= 2) ? 1 : $clog2(numReq);
  endfunction

endpackage

// File: rtl/input_memory_read_arbiter_if.sv
// Lane-side and memory-side read channels of the arbiter.
// master: the arbiter. slave: the lanes plus the input memory.
interface input_memory_read_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        clientReadReq;
  logic [NUM_REQ*ADDR_W-1:0] clientReadAdd;
  logic [NUM_REQ-1:0]        clientReadAck;
  logic [NUM_REQ-1:0]        clientReadDataValid;
  logic [DATA_W-1:0]         clientReadData;
  logic                      inputMemoryReadReq;
  logic                      inputMemoryReadAck;
  logic [ADDR_W-1:0]         inputMemoryReadAdd;
  logic                      inputMemoryReadDataValid;
  logic [DATA_W-1:0]         inputMemoryReadData;

  modport master (
    input  clientReadReq, clientReadAdd,
    input  inputMemoryReadAck, inputMemoryReadDataValid, inputMemoryReadData,
    output clientReadAck, clientReadDataValid, clientReadData,
    output inputMemoryReadReq, inputMemoryReadAdd
  );

  modport slave (
    output clientReadReq, clientReadAdd,
    output inputMemoryReadAck, inputMemoryReadDataValid, inputMemoryReadData,
    input  clientReadAck, clientReadDataValid, clientReadData,
    input  inputMemoryReadReq, inputMemoryReadAdd
  );
endinterface

// File: rtl/input_memory_read_arbiter_tag_fifo.sv
// In-order FIFO of granted lane IDs; head is visible without a pop (show-ahead).
module read_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign dout   = mem[rdPtr];

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

  // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/input_memory_read_arbiter.sv
// Round-robin arbiter sharing one input-memory read channel among NUM_REQ lanes,
// with an in-order tag FIFO routing each returned word to its requesting lane.
module input_memory_read_arbiter
  import input_memory_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = DEFAULT_NUM_REQ,
  parameter int ADDR_W          = DEFAULT_ADDR_W,
  parameter int DATA_W          = DEFAULT_DATA_W,
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1),
  localparam int LANE_W = laneIdWidth(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input_memory_read_arbiter_if.master          bus,
  output logic [CNT_W-1:0]                     outstanding,
  output logic                                 unexpectedData
);
  arbState_t         state;
  logic [LANE_W-1:0] grant;
  logic [LANE_W-1:0] rrPtr;
  logic [ADDR_W-1:0] addrReg;
  logic              memReqReg;
  logic              pickFound;
  logic [LANE_W-1:0] pickLane;
  logic              tagPush;
  logic              tagPop;
  logic [LANE_W-1:0] tagHead;
  logic              tagFull;
  logic              tagEmpty;
  logic [NUM_REQ-1:0] dataValidReg;
  logic [DATA_W-1:0]  dataReg;
  logic               unexpectedReg;

  assign tagPush = (state == ISSUE) && bus.inputMemoryReadAck;
  assign tagPop  = bus.inputMemoryReadDataValid && !tagEmpty;

  read_tag_fifo #(
    .WIDTH (LANE_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tagFifo (
    .clk   (clk),
    .reset (reset),
    .push  (tagPush),
    .pop   (tagPop),
    .din   (grant),
    .dout  (tagHead),
    .count (outstanding),
    .full  (tagFull),
    .empty (tagEmpty)
  );

  // Round-robin pick: first requesting lane at or after rrPtr, wrapping upward.
  always_comb begin
    pickFound = 1'b0;
    pickLane  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pickFound && bus.clientReadReq[(int'(rrPtr) + k) % NUM_REQ]) begin
        pickFound = 1'b1;
        pickLane  = LANE_W'((int'(rrPtr) + k) % NUM_REQ);
      end
    end
  end

  // Grant/issue FSM; memory request and address are registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      rrPtr     <= '0;
      addrReg   <= '0;
      memReqReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pickFound && !tagFull) begin
            grant     <= pickLane;
            addrReg   <= bus.clientReadAdd[int'(pickLane)*ADDR_W +: ADDR_W];
            memReqReg <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.inputMemoryReadAck) begin
            memReqReg <= 1'b0;
            rrPtr     <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane ack follows the memory ack combinationally while a grant is in flight.
  always_comb begin
    bus.clientReadAck = '0;
    if (tagPush) bus.clientReadAck[grant] = 1'b1;
  end

  // Return path: route the registered word to the FIFO head; flag data nobody asked for.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataValidReg  <= '0;
      dataReg       <= '0;
      unexpectedReg <= 1'b0;
    end else begin
      dataValidReg <= '0;
      if (tagPop) begin
        dataValidReg[tagHead] <= 1'b1;
        dataReg               <= bus.inputMemoryReadData;
      end
      if (bus.inputMemoryReadDataValid && tagEmpty) unexpectedReg <= 1'b1;
    end
  end

  assign bus.inputMemoryReadReq  = memReqReg;
  assign bus.inputMemoryReadAdd  = addrReg;
  assign bus.clientReadDataValid = dataValidReg;
  assign bus.clientReadData      = dataReg;
  assign unexpectedData          = unexpectedReg;
endmodule

// File: tb/tb_input_memory_read_arbiter.sv
// Directed self-checking bench for input_memory_read_arbiter (4 lanes, depth 4).
module tb_input_memory_read_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] outstanding;
  logic       unexpectedData;
  int         checks = 0;
  int         failures = 0;

  input_memory_read_arbiter_if #(.NUM_REQ(4), .ADDR_W(17), .DATA_W(32)) bus ();

  input_memory_read_arbiter #(
    .NUM_REQ(4), .ADDR_W(17), .DATA_W(32), .MAX_OUTSTANDING(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .outstanding    (outstanding),
    .unexpectedData (unexpectedData)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int lane, input logic [16:0] a);
    bus.clientReadAdd[lane*17 +: 17] = a;
  endtask

  // Lane issues one read alone; memory acks on the first request cycle.
  task automatic issue_one(input int lane, input logic [16:0] a);
    logic [3:0] expAck;
    expAck = 4'b0001 << lane;
    bus.clientReadReq = 4'b0000;
    bus.clientReadReq[lane] = 1'b1;
    set_addr(lane, a);
    tick();
    checks++; if (bus.inputMemoryReadReq !== 1'b1) begin failures++; $display("FAIL issue_req lane=%0d: got %b expected 1", lane, bus.inputMemoryReadReq); end
    checks++; if (bus.inputMemoryReadAdd !== a) begin failures++; $display("FAIL issue_addr lane=%0d: got %h expected %h", lane, bus.inputMemoryReadAdd, a); end
    bus.inputMemoryReadAck = 1'b1;
    #1;
    checks++; if (bus.clientReadAck !== expAck) begin failures++; $display("FAIL issue_ack lane=%0d: got %b expected %b", lane, bus.clientReadAck, expAck); end
    $display("txn ack lane=%0d addr=%h", lane, a);
    tick();
    bus.inputMemoryReadAck = 1'b0;
    bus.clientReadReq = 4'b0000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus.inputMemoryReadReq !== 1'b0) begin failures++; $display("FAIL rst_memreq: got %b expected 0", bus.inputMemoryReadReq); end
    checks++; if (bus.inputMemoryReadAdd !== 17'h0) begin failures++; $display("FAIL rst_addr: got %h expected 0", bus.inputMemoryReadAdd); end
    checks++; if (bus.clientReadAck !== 4'b0) begin failures++; $display("FAIL rst_ack: got %b expected 0", bus.clientReadAck); end
    checks++; if (bus.clientReadDataValid !== 4'b0) begin failures++; $display("FAIL rst_dv: got %b expected 0", bus.clientReadDataValid); end
    checks++; if (bus.clientReadData !== 32'h0) begin failures++; $display("FAIL rst_data: got %h expected 0", bus.clientReadData); end
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL rst_outstanding: got %0d expected 0", outstanding); end
    checks++; if (unexpectedData !== 1'b0) begin failures++; $display("FAIL rst_unexpected: got %b expected 0", unexpectedData); end
    reset = 1'b0;
    $display("txn reset released");
  endtask

  // All lanes request; immediate acks; grants 0,1,2,3 on cycles 1,3,5,7.
  task automatic test_fairness();
    int n;
    logic [3:0] expAck;
    n = 0;
    for (int i = 0; i < 4; i++) set_addr(i, 17'(17'h100 + i));
    bus.clientReadReq = 4'b1111;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      bus.inputMemoryReadAck = 1'b0;
      checks++; if (bus.inputMemoryReadReq !== cyc[0]) begin failures++; $display("FAIL fair_req cyc=%0d: got %b expected %b", cyc, bus.inputMemoryReadReq, cyc[0]); end
      if (bus.inputMemoryReadReq === 1'b1 && n < 4) begin
        expAck = 4'b0001 << n;
        bus.inputMemoryReadAck = 1'b1;
        #1;
        checks++; if (bus.clientReadAck !== expAck) begin failures++; $display("FAIL fair_ack n=%0d: got %b expected %b", n, bus.clientReadAck, expAck); end
        checks++; if (bus.inputMemoryReadAdd !== 17'(17'h100 + n)) begin failures++; $display("FAIL fair_addr n=%0d: got %h expected %h", n, bus.inputMemoryReadAdd, 17'h100 + n); end
        $display("txn fair grant lane=%0d cyc=%0d", n, cyc);
        n++;
      end
    end
    bus.inputMemoryReadAck = 1'b0;
    checks++; if (outstanding !== 3'd4) begin failures++; $display("FAIL fair_outstanding: got %0d expected 4", outstanding); end
  endtask

  // FIFO full: no fifth request until a data beat frees a slot.
  task automatic test_backpressure();
    int expLane[4] = '{1, 2, 3, 0};
    logic [3:0] expDv;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.inputMemoryReadReq !== 1'b0) begin failures++; $display("FAIL bp_noreq i=%0d: got %b expected 0", i, bus.inputMemoryReadReq); end
    end
    bus.inputMemoryReadDataValid = 1'b1;
    bus.inputMemoryReadData = 32'hA0A0A0A0;
    tick();
    bus.inputMemoryReadDataValid = 1'b0;
    checks++; if (bus.clientReadDataValid !== 4'b0001) begin failures++; $display("FAIL bp_dv: got %b expected 0001", bus.clientReadDataValid); end
    checks++; if (bus.clientReadData !== 32'hA0A0A0A0) begin failures++; $display("FAIL bp_data: got %h expected a0a0a0a0", bus.clientReadData); end
    checks++; if (outstanding !== 3'd3) begin failures++; $display("FAIL bp_outstanding3: got %0d expected 3", outstanding); end
    tick();
    checks++; if (bus.inputMemoryReadReq !== 1'b1) begin failures++; $display("FAIL bp_regrant_req: got %b expected 1", bus.inputMemoryReadReq); end
    checks++; if (bus.inputMemoryReadAdd !== 17'h100) begin failures++; $display("FAIL bp_regrant_addr: got %h expected 00100", bus.inputMemoryReadAdd); end
    bus.inputMemoryReadAck = 1'b1;
    #1;
    checks++; if (bus.clientReadAck !== 4'b0001) begin failures++; $display("FAIL bp_regrant_ack: got %b expected 0001", bus.clientReadAck); end
    $display("txn bp regrant lane=0");
    tick();
    bus.inputMemoryReadAck = 1'b0;
    bus.clientReadReq = 4'b0000;
    checks++; if (outstanding !== 3'd4) begin failures++; $display("FAIL bp_outstanding4: got %0d expected 4", outstanding); end
    // Drain back-to-back
    for (int i = 0; i < 4; i++) begin
      bus.inputMemoryReadDataValid = 1'b1;
      bus.inputMemoryReadData = 32'hB0 + i;
      tick();
      expDv = 4'b0001 << expLane[i];
      checks++; if (bus.clientReadDataValid !== expDv) begin failures++; $display("FAIL drain_dv i=%0d: got %b expected %b", i, bus.clientReadDataValid, expDv); end
      checks++; if (bus.clientReadData !== 32'hB0 + i) begin failures++; $display("FAIL drain_data i=%0d: got %h expected %h", i, bus.clientReadData, 32'hB0 + i); end
      $display("txn drain lane=%0d data=%h", expLane[i], bus.clientReadData);
    end
    bus.inputMemoryReadDataValid = 1'b0;
    tick();
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL drain_outstanding: got %0d expected 0", outstanding); end
    checks++; if (bus.clientReadDataValid !== 4'b0) begin failures++; $display("FAIL drain_dv_idle: got %b expected 0", bus.clientReadDataValid); end
  endtask

  // Lane 2, ack withheld 3 cycles, data 5 cycles after ack.
  task automatic test_single_lane();
    bus.clientReadReq = 4'b0100;
    set_addr(2, 17'h00010);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.inputMemoryReadReq !== 1'b1) begin failures++; $display("FAIL single_req i=%0d: got %b expected 1", i, bus.inputMemoryReadReq); end
      checks++; if (bus.inputMemoryReadAdd !== 17'h00010) begin failures++; $display("FAIL single_addr i=%0d: got %h expected 00010", i, bus.inputMemoryReadAdd); end
      checks++; if (bus.clientReadAck !== 4'b0) begin failures++; $display("FAIL single_noack i=%0d: got %b expected 0", i, bus.clientReadAck); end
    end
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL single_outstanding0: got %0d expected 0", outstanding); end
    bus.inputMemoryReadAck = 1'b1;
    #1;
    checks++; if (bus.clientReadAck !== 4'b0100) begin failures++; $display("FAIL single_ack: got %b expected 0100", bus.clientReadAck); end
    $display("txn single ack lane=2 addr=00010");
    tick();
    bus.inputMemoryReadAck = 1'b0;
    bus.clientReadReq = 4'b0000;
    #1;
    checks++; if (outstanding !== 3'd1) begin failures++; $display("FAIL single_outstanding1: got %0d expected 1", outstanding); end
    checks++; if (bus.inputMemoryReadReq !== 1'b0) begin failures++; $display("FAIL single_req_drop: got %b expected 0", bus.inputMemoryReadReq); end
    checks++; if (bus.clientReadAck !== 4'b0) begin failures++; $display("FAIL single_ack_once: got %b expected 0", bus.clientReadAck); end
    for (int i = 0; i < 4; i++) tick();
    bus.inputMemoryReadDataValid = 1'b1;
    bus.inputMemoryReadData = 32'hDEADBEEF;
    tick();
    bus.inputMemoryReadDataValid = 1'b0;
    checks++; if (bus.clientReadDataValid !== 4'b0100) begin failures++; $display("FAIL single_dv: got %b expected 0100", bus.clientReadDataValid); end
    checks++; if (bus.clientReadData !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data: got %h expected deadbeef", bus.clientReadData); end
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL single_outstanding_end: got %0d expected 0", outstanding); end
    $display("txn single data lane=2 data=%h", bus.clientReadData);
    tick();
    checks++; if (bus.clientReadDataValid !== 4'b0) begin failures++; $display("FAIL single_dv_pulse: got %b expected 0", bus.clientReadDataValid); end
  endtask

  // Lanes 3,1,0 issue; three consecutive beats route back in that order.
  task automatic test_ordering();
    int lanes[3] = '{3, 1, 0};
    logic [31:0] words[3] = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
    logic [3:0] expDv;
    issue_one(3, 17'h00300);
    issue_one(1, 17'h00101);
    issue_one(0, 17'h000AA);
    checks++; if (outstanding !== 3'd3) begin failures++; $display("FAIL order_outstanding: got %0d expected 3", outstanding); end
    for (int i = 0; i < 3; i++) begin
      bus.inputMemoryReadDataValid = 1'b1;
      bus.inputMemoryReadData = words[i];
      tick();
      expDv = 4'b0001 << lanes[i];
      checks++; if (bus.clientReadDataValid !== expDv) begin failures++; $display("FAIL order_dv i=%0d: got %b expected %b", i, bus.clientReadDataValid, expDv); end
      checks++; if (bus.clientReadData !== words[i]) begin failures++; $display("FAIL order_data i=%0d: got %h expected %h", i, bus.clientReadData, words[i]); end
      $display("txn order data lane=%0d data=%h", lanes[i], bus.clientReadData);
    end
    bus.inputMemoryReadDataValid = 1'b0;
    tick();
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL order_outstanding_end: got %0d expected 0", outstanding); end
  endtask

  // Ack and data beat in the same cycle at outstanding=2.
  task automatic test_simultaneous();
    int lanes[2] = '{2, 3};
    logic [3:0] expDv;
    issue_one(1, 17'h00011);
    issue_one(2, 17'h00022);
    checks++; if (outstanding !== 3'd2) begin failures++; $display("FAIL sim_outstanding_pre: got %0d expected 2", outstanding); end
    bus.clientReadReq = 4'b1000;
    set_addr(3, 17'h00033);
    tick();
    checks++; if (bus.inputMemoryReadReq !== 1'b1) begin failures++; $display("FAIL sim_req: got %b expected 1", bus.inputMemoryReadReq); end
    bus.inputMemoryReadAck = 1'b1;
    bus.inputMemoryReadDataValid = 1'b1;
    bus.inputMemoryReadData = 32'h55555555;
    #1;
    checks++; if (bus.clientReadAck !== 4'b1000) begin failures++; $display("FAIL sim_ack: got %b expected 1000", bus.clientReadAck); end
    tick();
    bus.inputMemoryReadAck = 1'b0;
    bus.inputMemoryReadDataValid = 1'b0;
    bus.clientReadReq = 4'b0000;
    checks++; if (outstanding !== 3'd2) begin failures++; $display("FAIL sim_outstanding: got %0d expected 2", outstanding); end
    checks++; if (bus.clientReadDataValid !== 4'b0010) begin failures++; $display("FAIL sim_dv: got %b expected 0010", bus.clientReadDataValid); end
    checks++; if (bus.clientReadData !== 32'h55555555) begin failures++; $display("FAIL sim_data: got %h expected 55555555", bus.clientReadData); end
    $display("txn sim push+pop lane=1 data=%h", bus.clientReadData);
    for (int i = 0; i < 2; i++) begin
      bus.inputMemoryReadDataValid = 1'b1;
      bus.inputMemoryReadData = 32'hC0 + i;
      tick();
      expDv = 4'b0001 << lanes[i];
      checks++; if (bus.clientReadDataValid !== expDv) begin failures++; $display("FAIL sim_drain_dv i=%0d: got %b expected %b", i, bus.clientReadDataValid, expDv); end
    end
    bus.inputMemoryReadDataValid = 1'b0;
    tick();
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL sim_outstanding_end: got %0d expected 0", outstanding); end
  endtask

  // Unexpected data, sticky flag, reset mid-ISSUE, stale word after reset.
  task automatic test_errors();
    bus.inputMemoryReadDataValid = 1'b1;
    bus.inputMemoryReadData = 32'h12345678;
    tick();
    bus.inputMemoryReadDataValid = 1'b0;
    checks++; if (bus.clientReadDataValid !== 4'b0) begin failures++; $display("FAIL err_no_dv: got %b expected 0", bus.clientReadDataValid); end
    checks++; if (unexpectedData !== 1'b1) begin failures++; $display("FAIL err_flag: got %b expected 1", unexpectedData); end
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL err_outstanding: got %0d expected 0", outstanding); end
    tick();
    checks++; if (unexpectedData !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b expected 1", unexpectedData); end
    $display("txn unexpected data dropped");
    bus.clientReadReq = 4'b0001;
    set_addr(0, 17'h0001F);
    tick();
    checks++; if (bus.inputMemoryReadReq !== 1'b1) begin failures++; $display("FAIL err_issue_req: got %b expected 1", bus.inputMemoryReadReq); end
    reset = 1'b1;
    bus.inputMemoryReadAck = 1'b1;
    tick();
    reset = 1'b0;
    bus.clientReadReq = 4'b0000;
    #1;
    checks++; if (bus.clientReadAck !== 4'b0) begin failures++; $display("FAIL midrst_ack: got %b expected 0", bus.clientReadAck); end
    bus.inputMemoryReadAck = 1'b0;
    checks++; if (bus.inputMemoryReadReq !== 1'b0) begin failures++; $display("FAIL midrst_req: got %b expected 0", bus.inputMemoryReadReq); end
    checks++; if (bus.inputMemoryReadAdd !== 17'h0) begin failures++; $display("FAIL midrst_addr: got %h expected 0", bus.inputMemoryReadAdd); end
    checks++; if (bus.clientReadData !== 32'h0) begin failures++; $display("FAIL midrst_data: got %h expected 0", bus.clientReadData); end
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL midrst_outstanding: got %0d expected 0", outstanding); end
    checks++; if (unexpectedData !== 1'b0) begin failures++; $display("FAIL midrst_flag: got %b expected 0", unexpectedData); end
    $display("txn reset mid-issue");
    tick();
    bus.inputMemoryReadDataValid = 1'b1;
    bus.inputMemoryReadData = 32'h0BADF00D;
    tick();
    bus.inputMemoryReadDataValid = 1'b0;
    checks++; if (unexpectedData !== 1'b1) begin failures++; $display("FAIL stale_flag: got %b expected 1", unexpectedData); end
    checks++; if (bus.clientReadDataValid !== 4'b0) begin failures++; $display("FAIL stale_dv: got %b expected 0", bus.clientReadDataValid); end
    $display("txn stale pre-reset word dropped");
  endtask

  initial begin
    reset = 1'b1;
    bus.clientReadReq = '0;
    bus.clientReadAdd = '0;
    bus.inputMemoryReadAck = 1'b0;
    bus.inputMemoryReadDataValid = 1'b0;
    bus.inputMemoryReadData = '0;
    test_reset();
    test_fairness();
    test_backpressure();
    test_single_lane();
    test_ordering();
    test_simultaneous();
    test_errors();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
